// File: rtl/spi_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : spi_cfg_sequencer
// Brief    : Buffers 16-bit SPI configuration words in a small FIFO and
//            launches one SPI shift-stage transaction per word, with a
//            programmable idle gap between transactions.
// Options  : SPI_CFG_SEQ_TIMEOUT_EN - when defined, WAIT_BUSY is bounded by
//            TIMEOUT_CYCLES and a sticky err flag reports a lost word.
// Revision : 1.0 - initial release
// ============================================================================
module spi_cfg_sequencer #(
  parameter int unsigned FIFO_AW        = 3,
  parameter logic [7:0]  GAP_CYCLES     = 8'd4,
  parameter logic [7:0]  TIMEOUT_CYCLES = 8'd16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [15:0]        wr_data,
  output logic               fifo_full,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               overflow,
  input  logic               spi_ready,
  output logic               spi_start,
  output logic [15:0]        spi_data,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int unsigned          c_DEPTH      = 2 ** FIFO_AW;
  localparam logic [FIFO_AW-1:0]   c_PTR_ONE    = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]     c_LEVEL_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0]     c_LEVEL_FULL = (FIFO_AW + 1)'(c_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_BUSY = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_GAP       = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [15:0]          r_mem [c_DEPTH];
  logic [FIFO_AW-1:0]   r_wr_ptr;
  logic [FIFO_AW-1:0]   r_rd_ptr;
  logic [FIFO_AW:0]     r_level;

  logic                 w_empty;
  logic                 w_full;
  logic                 w_launch;
  logic                 w_push;
  logic                 w_push_drop;
  logic                 w_done_nxt;

  logic [7:0]           r_gap_cnt;
  logic [7:0]           w_gap_cnt_nxt;

  logic                 r_spi_start;
  logic [15:0]          r_spi_data;
  logic                 r_done;
  logic                 r_overflow;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == c_LEVEL_FULL);

  // A launch frees one slot in the same cycle, so a push while full is still
  // accepted when it coincides with a pop.
  assign w_push      = wr_en && (!w_full || w_launch);
  assign w_push_drop = wr_en && w_full && !w_launch;

`ifdef SPI_CFG_SEQ_TIMEOUT_EN
  logic [7:0] r_to_cnt;
  logic [7:0] w_to_cnt_nxt;
  logic       w_timeout;
  logic       r_err;
`else
  // Timeout limit has no consumer when the watchdog is not built.
  logic       w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Next-state, launch/done strobes and counter updates for the sequencer.
  always_comb begin
    w_state_nxt   = r_state;
    w_launch      = 1'b0;
    w_done_nxt    = 1'b0;
    w_gap_cnt_nxt = r_gap_cnt;
`ifdef SPI_CFG_SEQ_TIMEOUT_EN
    w_to_cnt_nxt  = 8'd0;
    w_timeout     = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        // Launch only when the shift stage reports idle; otherwise hold off.
        if (!w_empty && spi_ready) begin
          w_launch    = 1'b1;
          w_state_nxt = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        // The shift stage keeps ready high one cycle after accepting start,
        // so only a low ready proves the transaction is under way.
        if (!spi_ready) begin
          w_state_nxt = S_WAIT_DONE;
        end
`ifdef SPI_CFG_SEQ_TIMEOUT_EN
        else if (r_to_cnt == TIMEOUT_CYCLES - 8'd1) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_to_cnt_nxt = r_to_cnt + 8'd1;
        end
`endif
      end
      S_WAIT_DONE: begin
        if (spi_ready) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = (GAP_CYCLES == 8'd0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_CYCLES - 8'd1) begin
          w_gap_cnt_nxt = 8'd0;
          w_state_nxt   = S_IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_gap_cnt <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_launch) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_push, w_launch})
        2'b10:   r_level <= r_level + c_LEVEL_ONE;
        2'b01:   r_level <= r_level - c_LEVEL_ONE;
        default: r_level <= r_level;
      endcase
      if (w_push_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Shift-stage handshake outputs; spi_data only moves at a launch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spi_start <= 1'b0;
      r_spi_data  <= 16'h0000;
      r_done      <= 1'b0;
    end else begin
      r_spi_start <= w_launch;
      r_done      <= w_done_nxt;
      if (w_launch) begin
        r_spi_data <= r_mem[r_rd_ptr];
      end
    end
  end

`ifdef SPI_CFG_SEQ_TIMEOUT_EN
  // Watchdog on the start handshake; a timeout loses the word for good.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= 8'd0;
      r_err    <= 1'b0;
    end else begin
      r_to_cnt <= w_to_cnt_nxt;
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign fifo_full  = w_full;
  assign fifo_level = r_level;
  assign overflow   = r_overflow;
  assign spi_start  = r_spi_start;
  assign spi_data   = r_spi_data;
  assign done       = r_done;
  assign busy       = (r_state != S_IDLE) || !w_empty;

endmodule
`default_nettype wire
